// File: rtl/pattern_pkg.sv
// Shared sizes, pointer types and the one-hot decode used by the pattern
// pointer control stage.
package pattern_pkg;

  localparam int BUFFER_SIZE  = 22;
  localparam int BUFFER_WIDTH = 8;
  localparam int NO_BUFS      = 8;
  localparam int FIELD_IDX_W  = 5;
  localparam int BUF_IDX_W    = 3;
  localparam int DIV_W        = 4;
  localparam int RD_COPIES    = 4;

  localparam logic [FIELD_IDX_W-1:0] FIELD_LIMIT = FIELD_IDX_W'(BUFFER_SIZE);

  typedef logic [BUFFER_SIZE-1:0] field_ptr_t;
  typedef logic [NO_BUFS-1:0]     buf_ptr_t;

  // Out-of-range indices decode to all-zero; callers gate those requests.
  function automatic field_ptr_t onehot(input logic [FIELD_IDX_W-1:0] idx);
    onehot = field_ptr_t'(1) << idx;
  endfunction

endpackage

// File: rtl/onehot_ptr.sv
// One-hot pointer register: load from a one-hot value, or rotate left by one
// with a single-clock wrap flag when leaving the top bit.
module onehot_ptr #(
  parameter int WIDTH = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set,
  input  logic [WIDTH-1:0] set_val,
  input  logic             adv,
  output logic [WIDTH-1:0] ptr,
  output logic             wrap
);

  logic [WIDTH-1:0] ptr_reg, ptr_next;
  logic             wrap_reg, wrap_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg  <= WIDTH'(1);
      wrap_reg <= 1'b0;
    end else begin
      ptr_reg  <= ptr_next;
      wrap_reg <= wrap_next;
    end
  end

  // A load never reports a wrap, even when it targets the last position.
  always_comb begin
    ptr_next  = ptr_reg;
    wrap_next = 1'b0;
    if (set) begin
      ptr_next = set_val;
    end else if (adv) begin
      ptr_next  = {ptr_reg[WIDTH-2:0], ptr_reg[WIDTH-1]};
      wrap_next = ptr_reg[WIDTH-1];
    end
  end

  assign ptr  = ptr_reg;
  assign wrap = wrap_reg;

endmodule

// File: rtl/pattern_pointer_ctrl.sv
// Upstream control for the pattern buffer bank: buffer pointer/select, four
// replicated read field pointers, write field pointer and write strobe/data.
module pattern_pointer_ctrl
  import pattern_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    buf_load,
  input  logic [BUF_IDX_W-1:0]    buf_idx,
  input  logic                    rd_set,
  input  logic [FIELD_IDX_W-1:0]  rd_idx,
  input  logic                    rd_adv,
  input  logic                    run,
  input  logic [DIV_W-1:0]        div,
  input  logic                    wr_req,
  input  logic [FIELD_IDX_W-1:0]  wr_idx,
  input  logic [BUFFER_WIDTH-1:0] wr_data,
  output buf_ptr_t                bufp,
  output buf_ptr_t                buffer_select,
  output field_ptr_t              fieldp,
  output field_ptr_t              fieldp2,
  output field_ptr_t              fieldp3,
  output field_ptr_t              fieldp4,
  output field_ptr_t              fieldwp,
  output logic [BUFFER_WIDTH-1:0] field_in,
  output logic                    field_write,
  output logic                    rd_wrap,
  output logic                    idx_err
);

  logic [DIV_W-1:0] tick_cnt_reg, tick_cnt_next;
  logic             tick;

  // The live div is compared every cycle; a count already past div has to
  // roll over through 4'hF before it can match again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt_reg <= '0;
    else        tick_cnt_reg <= tick_cnt_next;
  end

  always_comb begin
    tick          = 1'b0;
    tick_cnt_next = tick_cnt_reg + DIV_W'(1);
    if (!run) begin
      tick_cnt_next = '0;
    end else if (tick_cnt_reg == div) begin
      tick          = 1'b1;
      tick_cnt_next = '0;
    end
  end

  logic       rd_idx_ok, wr_idx_ok;
  logic       rd_set_ok, rd_adv_ok;
  field_ptr_t rd_set_val;

  assign rd_idx_ok  = (rd_idx < FIELD_LIMIT);
  assign wr_idx_ok  = (wr_idx < FIELD_LIMIT);
  assign rd_set_ok  = rd_set & rd_idx_ok;
  // Any rd_set, even a rejected one, blocks the advance for that cycle.
  assign rd_adv_ok  = (rd_adv | tick) & ~rd_set;
  assign rd_set_val = onehot(rd_idx);

  field_ptr_t           rd_ptr [RD_COPIES];
  logic [RD_COPIES-1:0] rd_wrap_vec;

  // Separate registers per copy so each bank quadrant gets its own driver.
  generate
    for (genvar gi = 0; gi < RD_COPIES; gi++) begin : g_rd_copy
      onehot_ptr #(.WIDTH(BUFFER_SIZE)) u_rd_ptr (
        .clk     (clk),
        .rst_n   (rst_n),
        .set     (rd_set_ok),
        .set_val (rd_set_val),
        .adv     (rd_adv_ok),
        .ptr     (rd_ptr[gi]),
        .wrap    (rd_wrap_vec[gi])
      );
    end
  endgenerate

  assign fieldp  = rd_ptr[0];
  assign fieldp2 = rd_ptr[1];
  assign fieldp3 = rd_ptr[2];
  assign fieldp4 = rd_ptr[3];
  assign rd_wrap = |rd_wrap_vec;

  buf_ptr_t                bufp_reg, bufp_next;
  buf_ptr_t                buffer_select_reg;
  field_ptr_t              fieldwp_reg, fieldwp_next;
  logic [BUFFER_WIDTH-1:0] field_in_reg, field_in_next;
  logic                    field_write_reg, field_write_next;
  logic                    idx_err_reg, idx_err_next;

  always_comb begin
    bufp_next        = bufp_reg;
    fieldwp_next     = fieldwp_reg;
    field_in_next    = field_in_reg;
    field_write_next = 1'b0;
    idx_err_next     = (rd_set & ~rd_idx_ok) | (wr_req & ~wr_idx_ok);
    if (buf_load) bufp_next = buf_ptr_t'(onehot({2'b00, buf_idx}));
    if (wr_req && wr_idx_ok) begin
      fieldwp_next     = onehot(wr_idx);
      field_in_next    = wr_data;
      field_write_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bufp_reg          <= buf_ptr_t'(1);
      buffer_select_reg <= buf_ptr_t'(1);
      fieldwp_reg       <= field_ptr_t'(1);
      field_in_reg      <= '0;
      field_write_reg   <= 1'b0;
      idx_err_reg       <= 1'b0;
    end else begin
      bufp_reg          <= bufp_next;
      buffer_select_reg <= bufp_reg;
      fieldwp_reg       <= fieldwp_next;
      field_in_reg      <= field_in_next;
      field_write_reg   <= field_write_next;
      idx_err_reg       <= idx_err_next;
    end
  end

  assign bufp          = bufp_reg;
  assign buffer_select = buffer_select_reg;
  assign fieldwp       = fieldwp_reg;
  assign field_in      = field_in_reg;
  assign field_write   = field_write_reg;
  assign idx_err       = idx_err_reg;

endmodule

// File: tb/tb_pattern_pointer_ctrl.sv
// Directed and randomized checks of pattern_pointer_ctrl against a
// position-based reference model.
module tb_pattern_pointer_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        buf_load;
  logic [2:0]  buf_idx;
  logic        rd_set;
  logic [4:0]  rd_idx;
  logic        rd_adv;
  logic        run;
  logic [3:0]  div;
  logic        wr_req;
  logic [4:0]  wr_idx;
  logic [7:0]  wr_data;
  logic [7:0]  bufp, buffer_select;
  logic [21:0] fieldp, fieldp2, fieldp3, fieldp4, fieldwp;
  logic [7:0]  field_in;
  logic        field_write, rd_wrap, idx_err;

  int checks   = 0;
  int failures = 0;

  pattern_pointer_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .buf_load      (buf_load),
    .buf_idx       (buf_idx),
    .rd_set        (rd_set),
    .rd_idx        (rd_idx),
    .rd_adv        (rd_adv),
    .run           (run),
    .div           (div),
    .wr_req        (wr_req),
    .wr_idx        (wr_idx),
    .wr_data       (wr_data),
    .bufp          (bufp),
    .buffer_select (buffer_select),
    .fieldp        (fieldp),
    .fieldp2       (fieldp2),
    .fieldp3       (fieldp3),
    .fieldp4       (fieldp4),
    .fieldwp       (fieldwp),
    .field_in      (field_in),
    .field_write   (field_write),
    .rd_wrap       (rd_wrap),
    .idx_err       (idx_err)
  );

  always #5 clk = ~clk;

  // Reference model: plain positions and counts, not one-hot vectors.
  int m_buf, m_bsel, m_rd, m_wr, m_fin, m_cnt;
  bit m_fw, m_wrap, m_err;

  task automatic m_reset();
    m_buf = 0; m_bsel = 0; m_rd = 0; m_wr = 0; m_fin = 0; m_cnt = 0;
    m_fw = 0; m_wrap = 0; m_err = 0;
  endtask

  task automatic m_update();
    bit tick;
    tick  = run && (m_cnt == int'(div));
    m_cnt = !run ? 0 : (tick ? 0 : (m_cnt + 1) % 16);
    m_bsel = m_buf;
    if (buf_load) m_buf = int'(buf_idx);
    m_wrap = 0;
    if (rd_set) begin
      if (rd_idx < 22) m_rd = int'(rd_idx);
    end else if (rd_adv || tick) begin
      if (m_rd == 21) m_wrap = 1;
      m_rd = (m_rd + 1) % 22;
    end
    m_err = (rd_set && rd_idx >= 22) || (wr_req && wr_idx >= 22);
    m_fw = 0;
    if (wr_req && wr_idx < 22) begin
      m_wr  = int'(wr_idx);
      m_fin = int'(wr_data);
      m_fw  = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".bufp"},    32'(bufp),          32'(1) << m_buf);
    chk({tag, ".bsel"},    32'(buffer_select), 32'(1) << m_bsel);
    chk({tag, ".fieldp"},  32'(fieldp),        32'(1) << m_rd);
    chk({tag, ".fieldp2"}, 32'(fieldp2),       32'(1) << m_rd);
    chk({tag, ".fieldp3"}, 32'(fieldp3),       32'(1) << m_rd);
    chk({tag, ".fieldp4"}, 32'(fieldp4),       32'(1) << m_rd);
    chk({tag, ".fieldwp"}, 32'(fieldwp),       32'(1) << m_wr);
    chk({tag, ".fin"},     32'(field_in),      32'(m_fin));
    chk({tag, ".fw"},      32'(field_write),   32'(m_fw));
    chk({tag, ".wrap"},    32'(rd_wrap),       32'(m_wrap));
    chk({tag, ".err"},     32'(idx_err),       32'(m_err));
  endtask

  task automatic idle();
    buf_load = 0; buf_idx = 0; rd_set = 0; rd_idx = 0; rd_adv = 0;
    wr_req = 0; wr_idx = 0; wr_data = 0;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (!rst_n) m_reset();
    else        m_update();
    #1;
    check_all(tag);
    $display("%s: bufp=%h bsel=%h fieldp=%h fieldwp=%h fin=%h fw=%b wrap=%b err=%b",
             tag, bufp, buffer_select, fieldp, fieldwp, field_in, field_write, rd_wrap, idx_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; run = 0; div = 0;
    idle();
    m_reset();

    // 1: reset and release
    step("t1_rst"); step("t1_rst");
    @(negedge clk) rst_n = 1;
    chk("t1.bufp",   32'(bufp),        32'h01);
    chk("t1.fieldp", 32'(fieldp4),     32'h000001);
    chk("t1.fw",     32'(field_write), 32'h0);

    // 2: buffer load, select one clock later
    @(posedge clk); #1;
    buf_load = 1; buf_idx = 5;
    step("t2_load");
    chk("t2.bufp", 32'(bufp), 32'h20);
    chk("t2.bsel_early", 32'(buffer_select), 32'h01);
    idle();
    step("t2_sel");
    chk("t2.bsel", 32'(buffer_select), 32'h20);

    // 3: read set then advance through the wrap
    rd_set = 1; rd_idx = 20;
    step("t3_set");
    idle(); rd_adv = 1;
    step("t3_adv1");
    chk("t3.adv1", 32'(fieldp), 32'(1) << 21);
    step("t3_adv2");
    chk("t3.adv2", 32'(fieldp3), 32'h000001);
    chk("t3.wrap", 32'(rd_wrap), 32'h1);
    idle();
    step("t3_idle");
    chk("t3.wrap_clr", 32'(rd_wrap), 32'h0);

    // 4: auto-advance every div+1 clocks, counter cleared by run=0
    run = 1; div = 3;
    for (int i = 0; i < 12; i++) step($sformatf("t4_run%0d", i));
    chk("t4.three_adv", 32'(fieldp), 32'(1) << 3);
    run = 0;
    for (int i = 0; i < 5; i++) step($sformatf("t4_stop%0d", i));
    chk("t4.stopped", 32'(fieldp), 32'(1) << 3);
    run = 1;
    for (int i = 0; i < 3; i++) step($sformatf("t4_rerun%0d", i));
    chk("t4.cleared", 32'(fieldp), 32'(1) << 3);
    step("t4_rerun3");
    chk("t4.adv_again", 32'(fieldp), 32'(1) << 4);
    run = 0;

    // 5: write with simultaneous buffer load, back-to-back write
    wr_req = 1; wr_idx = 7; wr_data = 8'hA5; buf_load = 1; buf_idx = 2;
    step("t5_wr7");
    chk("t5.fw1", 32'(field_write), 32'h1);
    chk("t5.wp7", 32'(fieldwp), 32'(1) << 7);
    chk("t5.fin", 32'(field_in), 32'hA5);
    chk("t5.bufp", 32'(bufp), 32'h04);
    buf_load = 0; wr_idx = 8; wr_data = 8'h3C;
    step("t5_wr8");
    chk("t5.fw2", 32'(field_write), 32'h1);
    chk("t5.wp8", 32'(fieldwp), 32'(1) << 8);
    idle();
    step("t5_idle");
    chk("t5.fw_off", 32'(field_write), 32'h0);
    chk("t5.wp_hold", 32'(fieldwp), 32'(1) << 8);

    // 6: out-of-range write, then reset in the middle of a burst
    wr_req = 1; wr_idx = 22; wr_data = 8'hFF;
    step("t6_bad");
    chk("t6.fw", 32'(field_write), 32'h0);
    chk("t6.wp", 32'(fieldwp), 32'(1) << 8);
    chk("t6.err", 32'(idx_err), 32'h1);
    idle();
    step("t6_idle");
    chk("t6.err_clr", 32'(idx_err), 32'h0);
    for (int i = 1; i <= 3; i++) begin
      wr_req = 1; wr_idx = 5'(i); wr_data = 8'(i * 17);
      step($sformatf("t6_burst%0d", i));
    end
    rst_n = 0;
    #1;
    m_reset();
    chk("t6.rst_fw", 32'(field_write), 32'h0);
    chk("t6.rst_wp", 32'(fieldwp), 32'h1);
    chk("t6.rst_fin", 32'(field_in), 32'h0);
    check_all("t6_rst");
    $display("t6_rst_async: fw=%b fieldwp=%h", field_write, fieldwp);
    step("t6_rst_hold");
    idle();
    @(negedge clk) rst_n = 1;

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      buf_load = ($urandom_range(0, 3) == 0);
      buf_idx  = 3'($urandom_range(0, 7));
      rd_set   = ($urandom_range(0, 7) == 0);
      rd_idx   = 5'($urandom_range(0, 23));
      rd_adv   = ($urandom_range(0, 2) == 0);
      wr_req   = ($urandom_range(0, 1) == 0);
      wr_idx   = 5'($urandom_range(0, 23));
      wr_data  = 8'($urandom);
      if ($urandom_range(0, 15) == 0) run = ~run;
      if ($urandom_range(0, 15) == 0) div = 4'($urandom_range(0, 15));
      step($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
